neo_pixel_controller: RTL and testbench

Downstream consumer of the load/send producer FSM. It holds a NUM_PIXELS x 24-bit frame buffer written through the load_color interface, and on send_it serializes the frame to a WS2812-style single-wire LED strip on neo_data. After the frame it holds the line low for the latch/reset gap. It reports readiness and progress back to the producer through ready_to_load, ready_to_send, begin_send, done_send and done_wait.

---
 rtl/neo_pkg.sv | 40 ++++
 rtl/neo_bit_encoder.sv | 66 ++++++
 rtl/neo_pixel_controller.sv | 186 ++++++++++++++++++
 tb/tb_neo_pixel_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_pkg.sv
// ---------------------------------------------------------------------------
// neo_pkg
// Shared definitions for the WS2812-style pixel controller: colour index
// constants, default bit timing at 50 MHz, the controller state type, the
// per-pixel storage type and a helper that sizes the cycle counters.
// No ports (package).
// ---------------------------------------------------------------------------
package neo_pkg;

  localparam logic [1:0] COLOR_RED   = 2'd0;
  localparam logic [1:0] COLOR_GREEN = 2'd1;
  localparam logic [1:0] COLOR_BLUE  = 2'd2;

  localparam int DEF_NUM_PIXELS  = 5;
  localparam int DEF_T0H_CYCLES  = 18;    // 0.35 us
  localparam int DEF_T1H_CYCLES  = 35;    // 0.70 us
  localparam int DEF_BIT_CYCLES  = 63;    // 1.25 us
  localparam int DEF_WAIT_CYCLES = 2500;  // 50 us latch gap

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_HIGH,
    ST_SEND_LOW,
    ST_WAIT
  } neo_state_e;

  // Field order equals wire order (green, red, blue, each MSB first), so the
  // packed 24-bit word leaves the chip MSB first.
  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } pixel_t;

  // Width of a counter that must reach the larger of the two durations.
  function automatic int cycle_cnt_width(input int bit_cycles, input int wait_cycles);
    return $clog2(((bit_cycles > wait_cycles) ? bit_cycles : wait_cycles) + 1);
  endfunction

endpackage

// File: rtl/neo_bit_encoder.sv
// ---------------------------------------------------------------------------
// neo_bit_encoder
// Generates one WS2812 bit cell: the line is high for T1H_CYCLES (bit=1) or
// T0H_CYCLES (bit=0), then low until the cell totals BIT_CYCLES.
// Ports:
//   clock     - system clock
//   reset_n   - asynchronous active-low reset, forces the line low
//   start     - begin a new cell on the next cycle (may coincide with bit_done
//               to produce back-to-back cells)
//   bit_value - value of the bit being sent; held stable by the caller for
//               the whole cell
//   data_out  - registered serial line
//   bit_done  - high during the last cycle of the current cell
// ---------------------------------------------------------------------------
module neo_bit_encoder
  import neo_pkg::*;
#(
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int CNT_W      = cycle_cnt_width(DEF_BIT_CYCLES, DEF_WAIT_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic bit_value,
  output logic data_out,
  output logic bit_done
);

  logic             active_q;
  logic             high_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] high_last;

  // cnt_q counts elapsed cycles of the cell from 0, so the compare values
  // are "duration - 1".
  assign high_last = bit_value ? CNT_W'(T1H_CYCLES - 1) : CNT_W'(T0H_CYCLES - 1);
  assign cnt_d     = cnt_q + 1'b1;
  assign bit_done  = active_q && !high_q && (cnt_q == CNT_W'(BIT_CYCLES - 1));
  assign data_out  = high_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      high_q   <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (bit_done) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (high_q && (cnt_q == high_last)) begin
          high_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/neo_pixel_controller.sv
// ---------------------------------------------------------------------------
// neo_pixel_controller
// Holds a NUM_PIXELS x 24-bit frame buffer loaded one colour byte at a time
// and, on send_it, serialises it to a WS2812-style LED strip followed by a
// low latch gap.
// Build option: define NEO_AUTO_CLEAR_EN to zero the whole frame buffer on
// the edge where done_send is high (each frame must then be reloaded).
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   load_color      - write strobe, honoured only in IDLE and not with send_it
//   pixel_index     - target pixel (writes to >= NUM_PIXELS are dropped)
//   color_index     - 0 red, 1 green, 2 blue, 3 dropped
//   color_level     - byte written
//   send_it         - start a frame, honoured only in IDLE
//   neo_data        - serial LED line
//   ready_to_load,
//   ready_to_send   - high in IDLE
//   begin_send      - high in the cycle a send is accepted
//   done_send       - high in the last cycle of the last bit
//   done_wait       - high in the last cycle of the latch gap
// ---------------------------------------------------------------------------
module neo_pixel_controller
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int T0H_CYCLES  = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES  = DEF_T1H_CYCLES,
  parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_color,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send,
  output logic       begin_send,
  output logic       done_send,
  output logic       done_wait
);

  localparam int FRAME_BITS = NUM_PIXELS * 24;
  localparam int BIDX_W     = $clog2(FRAME_BITS);
  localparam int CNT_W      = cycle_cnt_width(BIT_CYCLES, WAIT_CYCLES);

  neo_state_e            state_q;
  logic [BIDX_W-1:0]     bit_idx_q;
  logic [BIDX_W-1:0]     bit_idx_d;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_d;
  logic [FRAME_BITS-1:0] frame_bits;   // frame in wire order, bit 0 sent first

  logic sending;
  logic send_accept;
  logic write_en;
  logic last_bit;
  logic frame_end;
  logic enc_start;
  logic enc_data;
  logic enc_bit_done;
  logic bit_value;

  assign sending     = (state_q == ST_SEND_HIGH) || (state_q == ST_SEND_LOW);
  assign send_accept = (state_q == ST_IDLE) && send_it;
  // A simultaneous send_it wins over the load.
  assign write_en    = (state_q == ST_IDLE) && load_color && !send_it &&
                       (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
  assign last_bit    = (bit_idx_q == BIDX_W'(FRAME_BITS - 1));
  assign frame_end   = sending && enc_bit_done && last_bit;
  assign enc_start   = send_accept || (sending && enc_bit_done && !last_bit);
  // Read straight from the live buffer: loads cannot happen outside IDLE.
  assign bit_value   = frame_bits[bit_idx_q];
  assign bit_idx_d   = bit_idx_q + 1'b1;
  assign wait_cnt_d  = wait_cnt_q + 1'b1;

  // -------------------------------------------------------------------------
  // Frame buffer. Kept in flops because the serialiser taps any bit of it
  // combinationally.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pixel
    pixel_t pix_q;
    pixel_t pix_d;

    always_comb begin
      pix_d = pix_q;
      if (write_en && (pixel_index == 3'(gi))) begin
        case (color_index)
          COLOR_RED:   pix_d.red   = color_level;
          COLOR_GREEN: pix_d.green = color_level;
          COLOR_BLUE:  pix_d.blue  = color_level;
          default:     pix_d       = pix_q;
        endcase
      end
`ifdef NEO_AUTO_CLEAR_EN
      if (frame_end) begin
        pix_d = '0;
      end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pix_q <= '0;
      end else begin
        pix_q <= pix_d;
      end
    end

    for (genvar gj = 0; gj < 24; gj++) begin : g_bit
      assign frame_bits[gi*24 + gj] = pix_q[23 - gj];
    end
  end

  // -------------------------------------------------------------------------
  // Bit cell timing
  // -------------------------------------------------------------------------
  neo_bit_encoder #(
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .BIT_CYCLES (BIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_encoder (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (enc_start),
    .bit_value (bit_value),
    .data_out  (enc_data),
    .bit_done  (enc_bit_done)
  );

  // -------------------------------------------------------------------------
  // Controller FSM. SEND_HIGH/SEND_LOW track the encoder's line level; the
  // cell boundary itself is taken from bit_done in either send state so the
  // sequencing does not depend on how short the low phase is.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (send_accept) begin
            state_q   <= ST_SEND_HIGH;
            bit_idx_q <= '0;
          end
        end
        ST_SEND_HIGH, ST_SEND_LOW: begin
          if (enc_bit_done) begin
            if (last_bit) begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= '0;
            end else begin
              state_q   <= ST_SEND_HIGH;
              bit_idx_q <= bit_idx_d;
            end
          end else if (state_q == ST_SEND_HIGH && !enc_data) begin
            state_q <= ST_SEND_LOW;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign neo_data      = enc_data;
  assign ready_to_load = (state_q == ST_IDLE);
  assign ready_to_send = (state_q == ST_IDLE);
  assign begin_send    = send_accept;
  assign done_send     = frame_end;
  assign done_wait     = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: tb/tb_neo_pixel_controller.sv
// ---------------------------------------------------------------------------
// tb_neo_pixel_controller
// Directed + randomised bench for neo_pixel_controller at default parameters.
// A byte-level colour model predicts the serial waveform and decoded frame.
// ---------------------------------------------------------------------------
module tb_neo_pixel_controller;

  localparam int NP         = 5;
  localparam int T0H        = 18;
  localparam int T1H        = 35;
  localparam int BITC       = 63;
  localparam int WAITC      = 2500;
  localparam int FRAME_BITS = NP * 24;
  localparam int FRAME_CYC  = FRAME_BITS * BITC + WAITC;
`ifdef NEO_AUTO_CLEAR_EN
  localparam bit AUTO_CLR = 1'b1;
`else
  localparam bit AUTO_CLR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       begin_send;
  logic       done_send;
  logic       done_wait;

  int total = 0;
  int bad   = 0;

  // model[pixel][colour], colour index 0 red, 1 green, 2 blue
  logic [7:0] model [NP][3];

  always #5 clock = ~clock;

  neo_pixel_controller dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_color    (load_color),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .send_it       (send_it),
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .begin_send    (begin_send),
    .done_send     (done_send),
    .done_wait     (done_wait)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bit k: pixel k/24, then green, red, blue bytes, each MSB first.
  function automatic logic model_bit(input int k);
    int p;
    int o;
    logic [7:0] b;
    p = k / 24;
    o = k % 24;
    if (o < 8)       b = model[p][1];
    else if (o < 16) b = model[p][0];
    else             b = model[p][2];
    return b[7 - (o % 8)];
  endfunction

  // Expected line level in cycle c (1 = first cycle after begin_send).
  function automatic logic exp_level(input int c);
    int k;
    int pos;
    if (c > FRAME_BITS * BITC) return 1'b0;
    k   = (c - 1) / BITC;
    pos = (c - 1) % BITC;
    return (pos < (model_bit(k) ? T1H : T0H));
  endfunction

  task automatic clear_model();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        model[p][c] = 8'h00;
  endtask

  task automatic do_load(input int p, input int c, input int v);
    @(negedge clock);
    send_it     = 1'b0;
    load_color  = 1'b1;
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = 8'(v);
    if (p < NP && c != 3) model[p][c] = 8'(v);
    $display("load pix=%0d col=%0d lvl=0x%02h", p, c, v);
  endtask

  // Sends one frame and checks waveform, handshakes and decoded bytes.
  // busy_load: drive load_color (pixel 1 red 0x55) during SEND_HIGH and WAIT,
  //            plus send_it during WAIT; all of it must be ignored.
  // load_with_send: load pixel 3 green 0x77 together with send_it (dropped).
  task automatic run_frame(input string tag, input bit busy_load, input bit load_with_send);
    int hi [FRAME_BITS];
    int wave_err = 0;
    int rdy_err  = 0;
    int ds_cyc   = -1;
    int ds_n     = 0;
    int dw_cyc   = -1;
    int dw_n     = 0;
    for (int k = 0; k < FRAME_BITS; k++) hi[k] = 0;

    @(negedge clock);
    send_it     = 1'b1;
    load_color  = load_with_send;
    pixel_index = 3'd3;
    color_index = 2'd1;
    color_level = 8'h77;
    #1;
    check({tag, "_begin_send"}, 32'(begin_send), 32'd1);
    check({tag, "_ready_at_send"}, 32'(ready_to_send), 32'd1);

    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clock);
      send_it    = 1'b0;
      load_color = 1'b0;
      if (busy_load && ((c <= 10) || (c >= 9000 && c <= 9010))) begin
        load_color  = 1'b1;
        pixel_index = 3'd1;
        color_index = 2'd0;
        color_level = 8'h55;
        send_it     = (c >= 9000);
      end
      #1;
      if (neo_data !== exp_level(c)) wave_err++;
      if (c <= FRAME_BITS * BITC) hi[(c - 1) / BITC] += int'(neo_data);
      if (ready_to_load !== 1'b0 || ready_to_send !== 1'b0 || begin_send !== 1'b0) rdy_err++;
      if (done_send === 1'b1) begin ds_n++; ds_cyc = c; end
      if (done_wait === 1'b1) begin dw_n++; dw_cyc = c; end
    end

    @(negedge clock);
    send_it    = 1'b0;
    load_color = 1'b0;
    #1;
    check({tag, "_ready_after"}, 32'({ready_to_load, ready_to_send}), 32'd3);
    check({tag, "_wave_errors"}, 32'(wave_err), 32'd0);
    check({tag, "_busy_handshake_errors"}, 32'(rdy_err), 32'd0);
    check({tag, "_done_send_cycle"}, 32'(ds_cyc), 32'd7560);
    check({tag, "_done_send_pulses"}, 32'(ds_n), 32'd1);
    check({tag, "_done_wait_cycle"}, 32'(dw_cyc), 32'd10060);
    check({tag, "_done_wait_pulses"}, 32'(dw_n), 32'd1);

    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < 3; c++) begin
        logic [7:0] d;
        int base;
        base = p * 24 + ((c == 1) ? 0 : (c == 0) ? 8 : 16);
        d = 8'h00;
        for (int i = 0; i < 8; i++) d[7 - i] = (hi[base + i] > (T0H + T1H) / 2);
        check($sformatf("%s_pix%0d_col%0d", tag, p, c), 32'(d), 32'(model[p][c]));
      end
    end
    $display("frame %s sent, wave_errors=%0d", tag, wave_err);
    if (AUTO_CLR) clear_model();
  endtask

  initial begin
    int p;
    reset_n     = 1'b0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    pixel_index = 3'd0;
    color_index = 2'd0;
    color_level = 8'd0;
    clear_model();

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("rst_neo_data", 32'(neo_data), 32'd0);
    check("rst_ready_to_load", 32'(ready_to_load), 32'd1);
    check("rst_ready_to_send", 32'(ready_to_send), 32'd1);
    check("rst_begin_send", 32'(begin_send), 32'd0);
    check("rst_done_send", 32'(done_send), 32'd0);
    check("rst_done_wait", 32'(done_wait), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Frame 1: pixel 0 red 0xFF, with loads/sends attempted while busy
    do_load(0, 0, 8'hFF);
    run_frame("f1_red", 1'b1, 1'b0);

    // Frame 2: random loads (pixel 1 left alone), invalid targets, then
    // directed green/blue on pixel 2; a load issued together with send_it
    for (int i = 0; i < 12; i++) begin
      p = int'($urandom_range(0, 6));
      if (p >= 1) p++;
      do_load(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    do_load(5, 0, 8'h11);
    do_load(7, 2, 8'h12);
    do_load(1, 3, 8'h22);
    do_load(2, 1, 8'hA5);
    do_load(2, 2, 8'h3C);
    run_frame("f2_mix", 1'b0, 1'b1);

    // Reset in the middle of bit 40
    @(negedge clock);
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    repeat (40 * BITC + 4) @(negedge clock);
    #1;
    check("mid_bit40_line_high", 32'(neo_data), 32'd1);
    check("mid_busy_ready", 32'(ready_to_load), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_neo_data", 32'(neo_data), 32'd0);
    check("mid_reset_ready_to_load", 32'(ready_to_load), 32'd1);
    check("mid_reset_ready_to_send", 32'(ready_to_send), 32'd1);
    check("mid_reset_done_send", 32'(done_send), 32'd0);
    $display("reset asserted mid-frame at bit 40");
    clear_model();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Frame after reset without loads: all zero
    run_frame("f4_zero", 1'b0, 1'b0);

    // Pixel 4 blue 0x80, sent twice
    do_load(4, 2, 8'h80);
    run_frame("f5_blue", 1'b0, 1'b0);
    run_frame("f6_repeat", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
